axi_uart_rx_core: RTL and testbench
===================================

Name: axi_uart_rx_core

Overview:
- Receive-side UART engine: the other end of the SoC's 8N1 serial link. Today `uart_rx_i` is tied high at the top level; this block gives it a real consumer.
- Samples the asynchronous RX line, deserialises 8N1 frames and buffers received bytes in a small show-ahead FIFO.
- Exposes bytes through a valid/ready stream that the UART AXI slave wrapper drains as a read-data register. Frame-error and overrun status are reported alongside.

Parameters:
- FIFO_DEPTH, 8, receive FIFO entries; power of two, 2..64.
- DIV_WIDTH, 16, width of the clocks-per-bit divisor.

Ports:
- clk  input  1  core clock
- arst  input  1  asynchronous reset, active-high
- uart_rx_i  input  1  serial line, idle high, asynchronous to clk
- rx_en_i  input  1  receiver enable; new frames are accepted only while high
- baud_div_i  input  DIV_WIDTH  clk cycles per bit; legal minimum 4
- data_o  output  8  FIFO head byte
- valid_o  output  1  FIFO not empty
- ready_i  input  1  pop FIFO head when valid_o && ready_i
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low
- overrun_o  output  1  sticky: a byte was dropped because the FIFO was full
- clr_ovr_i  input  1  clears overrun_o
- fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset values:
  - 2-FF synchroniser and edge register = 1.
  - FSM = IDLE; counters = 0.
  - data_o = 0, valid_o = 0, frame_err_o = 0, overrun_o = 0, fifo_level_o = 0.
- Input path: `uart_rx_i` passes through a 2-FF synchroniser, giving `rx_s`. A registered copy `rx_q` is used for falling-edge detection.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If `rx_en_i` is high and a falling edge is seen (`rx_q`=1, `rx_s`=0), latch `baud_div_i` into `div_q`.
  - Load `cnt` with (div_q>>1)-1 and go to START.
  - `div_q` stays fixed for the whole frame; a change on `baud_div_i` mid-frame has no effect until the next frame.
- START:
  - Decrement `cnt`. At `cnt`==0, sample `rx_s`.
  - If the sample is 0: load `cnt` = div_q-1, set `bit_idx` = 0, go to DATA.
  - If the sample is 1: false start (glitch); go to IDLE with no status change.
- DATA:
  - At each `cnt`==0, shift `rx_s` into `shreg` MSB-first-in, so bits are received LSB first. Reload `cnt` = div_q-1 and increment `bit_idx`.
  - After the sample with `bit_idx`==7, go to STOP.
- STOP, at `cnt`==0:
  - If `rx_s`==1: push `shreg` to the FIFO. If the FIFO is full and there is no pop in the same cycle, drop the byte and set `overrun_o`.
  - If `rx_s`==0: pulse `frame_err_o` for 1 cycle and discard the byte.
  - Either way, return to IDLE.
  - A new frame then requires a fresh falling edge, so a held-low (break) line produces exactly one frame error.
- Latency:
  - Stop-bit sample point = falling edge + 2 (synchroniser) + 1 (edge register) + div/2 + 9*div cycles, approximately.
  - The pushed byte is visible on `valid_o`/`data_o` on the cycle after the stop sample.
- `rx_en_i` deasserted mid-frame: the current frame completes normally; only new starts are gated.
- FIFO:
  - Show-ahead: `data_o` = head entry, `valid_o` = level != 0.
  - Push and pop in the same cycle:
    - When full, the push is accepted and overrun is not set; level is unchanged.
    - When empty, the pop is ignored (`valid_o` was 0) and the push lands.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; level is tracked with an extra bit.
- Overrun:
  - `clr_ovr_i` clears `overrun_o`.
  - If a new overrun occurs in the same cycle as `clr_ovr_i`, the set wins.
- `baud_div_i` < 4: behaviour is undefined; software must not program it.

Decomposition:
- utils_pkg additions:
  - `uart_rx_st_t` enum {IDLE, START, DATA, STOP}.
  - `UART_DATA_W` = 8.
  - `UART_MIN_DIV` = 4.
- Sub-module `uart_rx_fifo`:
  - Parameterised depth, synchronous push/pop, level output, show-ahead read.
  - Reusable later for a TX-side FIFO.
- The FSM, synchroniser and divisor counter live in axi_uart_rx_core.

Test Plan:
- Single byte: baud_div=16, drive 0xA5 as 8N1 with 16 clk/bit, ready_i=0 → valid_o rises about 155 cycles after the start edge; data_o=0xA5; fifo_level_o=1; frame_err_o never pulses.
- Glitch rejection: baud_div=16, 4-cycle low pulse on an idle line → FSM returns to IDLE from START; valid_o stays 0; no frame_err_o.
- Framing error: send 0x3C with the stop bit forced low → exactly one frame_err_o pulse; fifo_level_o stays 0; the next good frame 0x55 is received correctly.
- Overrun: ready_i=0, send 9 bytes 0x00..0x08 with FIFO_DEPTH=8 → level=8, overrun_o=1, FIFO holds 0x00..0x07 in order. Then pulse clr_ovr_i → overrun_o=0.
- Full with simultaneous pop: FIFO full; assert ready_i for one cycle aligned with the 9th byte's stop sample → no overrun; level stays 8; head becomes 0x01; tail holds the new byte.
- Reset mid-frame, plus divisor latch: assert arst during DATA → all outputs return to reset values and a following 0x81 frame is received cleanly. Changing baud_div_i 16→8 mid-frame does not corrupt the in-flight byte.

Source files
------------

// File: rtl/axi_uart_rx_core_pkg.sv
// Shared types and constants for the UART receive path.
// Imported by the receive core and its FIFO.
package axi_uart_rx_core_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_st_t;

    localparam int UART_DATA_W  = 8;
    localparam int UART_MIN_DIV = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead synchronous FIFO with occupancy output.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo
    import axi_uart_rx_core_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = UART_DATA_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          valid_o,
    output logic          drop_o,
    output logic [AW:0]   level_o
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && (level != '0);
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && !do_push;

    assign dout_o  = mem[rd_ptr];
    assign valid_o = (level != '0);
    assign level_o = level;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din_i;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/axi_uart_rx_core.sv
// 8N1 UART receiver: synchroniser, start/data/stop FSM and receive FIFO.
// Frame-error is a one-cycle pulse; overrun is sticky until cleared.
module axi_uart_rx_core
    import axi_uart_rx_core_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   uart_rx_i,
    input  logic                   rx_en_i,
    input  logic [DIV_WIDTH-1:0]   baud_div_i,
    output logic [UART_DATA_W-1:0] data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   frame_err_o,
    output logic                   overrun_o,
    input  logic                   clr_ovr_i,
    output logic [LW-1:0]          fifo_level_o
);

    logic                   rx_m;
    logic                   rx_s;
    logic                   rx_q;
    uart_rx_st_t            state;
    logic [DIV_WIDTH-1:0]   div_q;
    logic [DIV_WIDTH-1:0]   cnt;
    logic [2:0]             bit_idx;
    logic [UART_DATA_W-1:0] shreg;
    logic                   push;
    logic                   drop;
    logic                   tick;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_q <= 1'b1;
        end else begin
            rx_m <= uart_rx_i;
            rx_s <= rx_m;
            rx_q <= rx_s;
        end
    end

    assign tick = (cnt == '0);
    assign push = (state == STOP) && tick && rx_s;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state       <= IDLE;
            div_q       <= '0;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rx_en_i && rx_q && !rx_s) begin
                        div_q <= baud_div_i;
                        cnt   <= (baud_div_i >> 1) - DIV_WIDTH'(1);
                        state <= START;
                    end
                end
                START: begin
                    if (!tick) begin
                        cnt <= cnt - DIV_WIDTH'(1);
                    end else if (!rx_s) begin
                        cnt     <= div_q - DIV_WIDTH'(1);
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (!tick) begin
                        cnt <= cnt - DIV_WIDTH'(1);
                    end else begin
                        shreg   <= {rx_s, shreg[UART_DATA_W-1:1]};
                        cnt     <= div_q - DIV_WIDTH'(1);
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (!tick) begin
                        cnt <= cnt - DIV_WIDTH'(1);
                    end else begin
                        frame_err_o <= !rx_s;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A fresh overrun outranks a clear arriving in the same cycle
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            overrun_o <= 1'b0;
        end else if (drop) begin
            overrun_o <= 1'b1;
        end else if (clr_ovr_i) begin
            overrun_o <= 1'b0;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (UART_DATA_W)
    ) u_fifo (
        .clk     (clk),
        .arst    (arst),
        .push_i  (push),
        .din_i   (shreg),
        .pop_i   (ready_i),
        .dout_o  (data_o),
        .valid_o (valid_o),
        .drop_o  (drop),
        .level_o (fifo_level_o)
    );

endmodule

// File: tb/tb_axi_uart_rx_core.sv
// Directed and randomized bench for axi_uart_rx_core.
// Expected bytes and status come from a queue-based model of the serial link.
module tb_axi_uart_rx_core;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          rx = 1'b1;
    logic          rx_en = 1'b1;
    logic [15:0]   baud = 16'd16;
    logic [7:0]    data;
    logic          valid;
    logic          ready = 1'b0;
    logic          ferr;
    logic          ovr;
    logic          clr = 1'b0;
    logic [LW-1:0] level;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rise_cyc = -1;
    int ferr_cnt = 0;
    logic valid_prev = 1'b0;

    logic [7:0] q[$];
    bit         ovr_m = 1'b0;
    int         ferr_m = 0;

    axi_uart_rx_core #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(16)) dut (
        .clk          (clk),
        .arst         (arst),
        .uart_rx_i    (rx),
        .rx_en_i      (rx_en),
        .baud_div_i   (baud),
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (ready),
        .frame_err_o  (ferr),
        .overrun_o    (ovr),
        .clr_ovr_i    (clr),
        .fifo_level_o (level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (valid && !valid_prev) rise_cyc = cyc;
        valid_prev = valid;
        if (ferr) ferr_cnt = ferr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame, bit time = div clk cycles, starting at posedge+1
    task automatic send_frame(input logic [7:0] b, input int div,
                              input bit stop_ok = 1'b1, input int pop_at = -1,
                              input int abort_at = -1, input int chg_at = -1,
                              input int chg_div = 0, input int en_off_at = -1);
        logic [9:0] fr;
        int idx;
        fr = {stop_ok, b, 1'b0};
        baud = 16'(div);
        for (int c = 0; c < 10 * div; c++) begin
            if (c == abort_at) begin
                arst = 1'b1;
                rx = 1'b1;
                ready = 1'b0;
                tick(2);
                arst = 1'b0;
                tick(2);
                return;
            end
            idx = c / div;
            rx = fr[idx[3:0]];
            ready = (c == pop_at);
            if (c == chg_at) baud = 16'(chg_div);
            if (c == en_off_at) rx_en = 1'b0;
            tick(1);
        end
        rx = 1'b1;
        ready = 1'b0;
        tick(2 * div);
    endtask

    function automatic void model_frame(input logic [7:0] b, input bit stop_ok, input bit popped);
        if (!stop_ok) begin
            ferr_m++;
        end else if (popped && q.size() > 0) begin
            void'(q.pop_front());
            q.push_back(b);
        end else if (q.size() < DEPTH) begin
            q.push_back(b);
        end else begin
            ovr_m = 1'b1;
        end
    endfunction

    task automatic check_status(input string tag);
        chk({tag, "_level"}, 32'(level), 32'(q.size()));
        chk({tag, "_ovr"}, 32'(ovr), 32'(ovr_m));
        chk({tag, "_ferr"}, 32'(ferr_cnt), 32'(ferr_m));
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) begin
            chk({tag, "_valid"}, 32'(valid), 32'd1);
            chk({tag, "_data"}, 32'(data), 32'(q[0]));
            chk({tag, "_lvl"}, 32'(level), 32'(q.size()));
            ready = 1'b1;
            tick(1);
            ready = 1'b0;
            void'(q.pop_front());
        end
        chk({tag, "_empty"}, 32'(valid), 32'd0);
        chk({tag, "_lvl0"}, 32'(level), 32'd0);
    endtask

    initial begin
        int st;
        int lat;
        int div;
        logic [7:0] b;
        bit ok;

        tick(3);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_ferr", 32'(ferr), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        arst = 1'b0;
        tick(4);

        st = cyc;
        send_frame(8'hA5, 16);
        lat = rise_cyc - st;
        chk("single_latency", 32'(lat >= 150 && lat <= 160), 32'd1);
        model_frame(8'hA5, 1'b1, 1'b0);
        check_status("single");
        chk("single_data", 32'(data), 32'hA5);
        drain("single");

        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        chk("glitch_valid", 32'(valid), 32'd0);
        check_status("glitch");

        send_frame(8'h3C, 16, 1'b0);
        model_frame(8'h3C, 1'b0, 1'b0);
        check_status("ferr");
        send_frame(8'h55, 16);
        model_frame(8'h55, 1'b1, 1'b0);
        check_status("after_ferr");
        drain("after_ferr");

        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            div = $urandom_range(6, 24);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(b, div, ok);
            model_frame(b, ok, 1'b0);
            check_status("rand");
        end
        drain("rand");

        for (int i = 0; i < 9; i++) begin
            send_frame(8'(i), 8);
            model_frame(8'(i), 1'b1, 1'b0);
        end
        check_status("ovr");
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        ovr_m = 1'b0;
        chk("ovr_clr", 32'(ovr), 32'd0);
        drain("ovr");

        for (int i = 0; i < 8; i++) begin
            send_frame(8'(8'h10 + i), 16);
            model_frame(8'(8'h10 + i), 1'b1, 1'b0);
        end
        send_frame(8'h18, 16, 1'b1, 2 + 1 + 16 / 2 + 9 * 16 - 1);
        model_frame(8'h18, 1'b1, 1'b1);
        check_status("fullpop");
        chk("fullpop_head", 32'(data), 32'h11);
        drain("fullpop");

        send_frame(8'h42, 16);
        model_frame(8'h42, 1'b1, 1'b0);
        send_frame(8'h99, 16, 1'b1, -1, 60);
        q.delete();
        chk("mrst_data", 32'(data), 32'd0);
        chk("mrst_valid", 32'(valid), 32'd0);
        chk("mrst_level", 32'(level), 32'd0);
        chk("mrst_ovr", 32'(ovr), 32'd0);
        send_frame(8'h81, 16);
        model_frame(8'h81, 1'b1, 1'b0);
        check_status("mrst");
        drain("mrst");

        send_frame(8'hC3, 16, 1'b1, -1, -1, 40, 8);
        model_frame(8'hC3, 1'b1, 1'b0);
        check_status("divchg");
        drain("divchg");

        rx_en = 1'b0;
        send_frame(8'h77, 12);
        check_status("rxen_off");
        rx_en = 1'b1;
        tick(2);
        send_frame(8'h6E, 12, 1'b1, -1, -1, -1, 0, 30);
        model_frame(8'h6E, 1'b1, 1'b0);
        check_status("rxen_mid");
        drain("rxen_mid");
        rx_en = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
